// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the feature-map pixel streamer.
// Build option: define FMAP_ZERO_PAD_EN to frame the image with a one-pixel zero border.
package conv_stream_pkg;

  // Frame-level FSM states
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_IMAGE_SIZE   = 222;
  localparam int unsigned DEF_NUM_CHANNELS = 64;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

  localparam int unsigned PIX_W  = DEF_NUM_CHANNELS * DEF_DATA_WIDTH;
  localparam int unsigned LANE_W = $clog2(DEF_NUM_CHANNELS);

  // Emitted frame width for a given unpadded feature-map size
  function automatic int unsigned frame_width(int unsigned image_size);
`ifdef FMAP_ZERO_PAD_EN
    return image_size + 2;
`else
    return image_size;
`endif
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding packed pixel words between the packer and the output stage.
// Head word is presented combinationally on rdata; a pop in the same cycle frees a slot for push.
module pixel_fifo
  import conv_stream_pkg::*;
#(
  parameter int unsigned Width = PIX_W,
  parameter int unsigned Depth = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q;
  logic [AddrW:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
              (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  // Pointer update; reset discards any buffered words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fmap_pixel_streamer.sv
// Packs channel-serial samples into pixel words and streams them out in raster order.
// Build option: FMAP_ZERO_PAD_EN adds a zero border around the frame (width IMAGE_SIZE+2).
module fmap_pixel_streamer
  import conv_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned IMAGE_SIZE   = DEF_IMAGE_SIZE,
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic [DATA_WIDTH-1:0]              ch_data,
  input  logic                               ch_valid,
  output logic                               ch_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] pixels_out,
  output logic                               pixel_valid,
  output logic [$clog2(IMAGE_SIZE+2)-1:0]    out_row,
  output logic [$clog2(IMAGE_SIZE+2)-1:0]    out_col,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int unsigned PixW   = NUM_CHANNELS * DATA_WIDTH;
  localparam int unsigned PartW  = PixW - DATA_WIDTH;
  localparam int unsigned LaneW  = $clog2(NUM_CHANNELS);
  localparam int unsigned CntW   = $clog2(IMAGE_SIZE + 2);
  localparam int unsigned FrameW = frame_width(IMAGE_SIZE);
  localparam int unsigned NumPix = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned PackW  = $clog2(NumPix + 1);

  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_CHANNELS - 1);
  localparam logic [CntW-1:0]  LastPos  = CntW'(FrameW - 1);
  localparam logic [PackW-1:0] PackMax  = PackW'(NumPix);

  state_e            state_q, state_d;
  logic [LaneW-1:0]  lane_q;
  logic [PartW-1:0]  word_q;
  logic [PackW-1:0]  packed_q;
  logic [CntW-1:0]   emit_row_q, emit_col_q;
  logic [CntW-1:0]   out_row_q, out_col_q;
  logic [PixW-1:0]   pixels_q;
  logic              pixel_valid_q;
  logic              last_sent_q;

  logic              lane_last;
  logic              all_packed;
  logic              accept;
  logic              push;
  logic [PixW-1:0]   push_data;
  logic              fifo_full, fifo_empty;
  logic [PixW-1:0]   fifo_rdata;
  logic              at_border;
  logic              is_last_pos;
  logic              emit;
  logic              pop;
  logic              frame_end;

  // Packer handshake and output-stage scheduling
  always_comb begin
    lane_last   = (lane_q == LastLane);
    all_packed  = (packed_q == PackMax);
    // Conservative: a same-cycle pop does not reopen the last lane when full
    ch_ready    = (state_q == StRun) && !all_packed && !(lane_last && fifo_full);
    accept      = ch_valid && ch_ready;
    push        = accept && lane_last;
    push_data   = {ch_data, word_q};
    is_last_pos = (emit_row_q == LastPos) && (emit_col_q == LastPos);
    emit        = (state_q == StRun) && !last_sent_q && (at_border || !fifo_empty);
    pop         = emit && !at_border;
    frame_end   = (state_q == StRun) && last_sent_q;
  end

`ifdef FMAP_ZERO_PAD_EN
  assign at_border = (emit_row_q == '0) || (emit_row_q == LastPos) ||
                     (emit_col_q == '0) || (emit_col_q == LastPos);
`else
  assign at_border = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next-state: leave RUN once the final pixel has been presented
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_start) state_d = StRun;
      StRun:   if (last_sent_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
  end

  // Lane packer: collect lanes 0..N-2, the last lane goes straight into the pushed word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q   <= '0;
      word_q   <= '0;
      packed_q <= '0;
    end else if (state_q != StRun) begin
      lane_q   <= '0;
      packed_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(NUM_CHANNELS) - 1; k++) begin
        if (lane_q == LaneW'(k)) word_q[k*DATA_WIDTH +: DATA_WIDTH] <= ch_data;
      end
      if (lane_last) begin
        lane_q   <= '0;
        packed_q <= packed_q + 1'b1;
      end else begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

  // Raster position of the next pixel to emit, plus end-of-frame marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      emit_row_q  <= '0;
      emit_col_q  <= '0;
      last_sent_q <= 1'b0;
    end else if (state_q != StRun) begin
      emit_row_q  <= '0;
      emit_col_q  <= '0;
      last_sent_q <= 1'b0;
    end else if (emit) begin
      if (is_last_pos) last_sent_q <= 1'b1;
      if (emit_col_q == LastPos) begin
        emit_col_q <= '0;
        emit_row_q <= (emit_row_q == LastPos) ? '0 : emit_row_q + 1'b1;
      end else begin
        emit_col_q <= emit_col_q + 1'b1;
      end
    end
  end

  // Output register: pixel data holds between emissions, position clears at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixels_q      <= '0;
      pixel_valid_q <= 1'b0;
      out_row_q     <= '0;
      out_col_q     <= '0;
    end else begin
      pixel_valid_q <= emit;
      if (emit) begin
        pixels_q  <= at_border ? '0 : fifo_rdata;
        out_row_q <= emit_row_q;
        out_col_q <= emit_col_q;
      end else if (frame_end) begin
        out_row_q <= '0;
        out_col_q <= '0;
      end
    end
  end

  assign pixels_out  = pixels_q;
  assign pixel_valid = pixel_valid_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;

  pixel_fifo #(
    .Width (PixW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
